poly_disp_scan: RTL and testbench
=================================

Name: poly_disp_scan

Overview:
- Reader end of the packed polyphony display bus: 256 bits, 16 slots of 16 bits; slot 2*i carries square-1 and slot 2*i+1 carries square-2 of voice pair i.
- On each frame strobe, takes a snapshot of the bus and walks the 16 slots one per cycle.
- Compares each slot against the last value delivered for it and emits a valid/ready event stream of changed slots (slot index, absolute MIDI note, on flag) to the keyboard overlay renderer.

Parameters:
- SLOTS, 16, number of slots on the bus (index width 4).
- SLOT_W, 16, bits per slot.
- NOTE_OFS, 36, offset added back to the stored note field.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_stb  in  1  one-cycle request to snapshot and scan pd_in.
- force_all  in  1  sampled with frame_stb; when 1, every slot is emitted regardless of change.
- pd_in  in  256  packed display bus, slot k = pd_in[16k+15:16k].
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts event.
- ev_slot  out  4  slot index of event.
- ev_note  out  7  absolute note.
- ev_on  out  1  note-on flag.
- ev_oor  out  1  note field out of range.
- busy  out  1  high in any state other than IDLE.
- scan_done  out  1  one-cycle pulse at end of scan.
- overrun  out  1  one-cycle pulse when frame_stb is dropped.

Behaviour:
- Slot format:
  - bits[8:0] = note - NOTE_OFS.
  - bit[9] = on.
  - bits[15:10] reserved; ignored by compare and decode.
- Decode:
  - ev_note = (bits[6:0] + NOTE_OFS) mod 128.
  - ev_oor = bits[8:7] != 0.
- Reset (async, any state, mid-scan included): state IDLE, idx 0, snapshot and prev shadow cleared to 0. All outputs 0 (ev_slot, ev_note, ev_on, ev_oor, ev_valid, busy, scan_done, overrun). A pending event is discarded.
- States: IDLE, SCAN, EMIT, DONE. All outputs registered.
- IDLE:
  - frame_stb=1 latches pd_in into snapshot, force_all into force_r, sets idx=0, moves to SCAN.
- SCAN, one slot per cycle:
  - changed = snapshot[idx][9:0] != prev[idx][9:0].
  - changed or force_r: load ev_* from the snapshot slot, set ev_valid, move to EMIT.
  - Otherwise, if idx==SLOTS-1 move to DONE, else idx+1.
- EMIT:
  - ev_valid and ev_* held stable until ev_ready=1 with ev_valid=1.
  - On that handshake: prev[idx] <= snapshot[idx], ev_valid=0, then DONE if idx==SLOTS-1, else idx+1 and SCAN.
  - ev_ready while ev_valid=0 is ignored.
- DONE: scan_done=1 for exactly this cycle, then IDLE. A frame_stb in DONE is dropped.
- frame_stb outside IDLE: ignored, snapshot unchanged, overrun=1 next cycle for one cycle.
- pd_in changes during a scan do not affect the scan in progress; only the snapshot is used.
- Latency, strobe sampled at edge 0:
  - Unchanged slots cost 1 cycle each.
  - No changes: scan_done high in cycle 17, busy high in cycles 1-17.
  - Each emitted slot costs 1 + (cycles until ev_ready) cycles.
- prev is updated only on handshake, so an un-emitted change is re-detected on the next frame.

Test Plan:
- Reset, pd_in=0, frame_stb -> no ev_valid, scan_done pulse in cycle 17, busy cycles 1-17.
- pd_in slot0=16'h0218, ev_ready=1, frame_stb -> one event: slot 0, note 60, on 1, oor 0. Repeat same frame -> no events.
- Slots 3=16'h0200 and 15=16'h0018, ev_ready held low 5 cycles on the first event -> ev_* stable during the stall. Events in order slot 3 (note 36, on) then slot 15 (note 60, off); scan_done after the second handshake.
- force_all=1 with unchanged bus -> 16 events, slots 0..15 in order. Slot with field 9'h180 -> ev_oor=1, ev_note=36.
- frame_stb again in cycle 5 of a scan -> overrun pulse in cycle 6, scan result unchanged, no extra scan.
- reset_n low while in EMIT -> ev_valid drops immediately. Next frame re-emits every nonzero slot, since prev was cleared.

Source files
------------

// File: rtl/poly_disp_scan.sv
// poly_disp_scan: reader end of the packed polyphony display bus.
// A frame strobe snapshots the 16-slot bus. The block then walks the slots one
// per cycle and emits a valid/ready event for every slot whose note/on field
// differs from the value last delivered for that slot (or every slot when
// force_all was set).
//
// Event handshake: ev_valid rises together with ev_slot/ev_note/ev_on/ev_oor.
// All of these stay stable until a cycle where ev_valid && ev_ready is seen at
// a rising clk edge, which is the transfer. ev_ready while ev_valid is low has
// no effect. The consumer may hold ev_ready low for any number of cycles.
module poly_disp_scan #(
  parameter int SLOTS    = 16,
  parameter int SLOT_W   = 16,
  parameter int NOTE_OFS = 36
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_stb,
  input  logic                      force_all,
  input  logic [SLOTS*SLOT_W-1:0]   pd_in,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [$clog2(SLOTS)-1:0]  ev_slot,
  output logic [6:0]                ev_note,
  output logic                      ev_on,
  output logic                      ev_oor,
  output logic                      busy,
  output logic                      scan_done,
  output logic                      overrun,
  output logic [1:0]                dbg_state
);

  localparam int IDX_W = $clog2(SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
  localparam logic [6:0] NOTE_OFS7 = 7'(NOTE_OFS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // Only bits [9:0] of each slot matter; the reserved upper bits are never stored.
  logic [SLOTS-1:0][9:0] snap_q, snap_d;
  logic [SLOTS-1:0][9:0] prev_q, prev_d;
  logic force_q, force_d;

  logic ev_valid_q, ev_valid_d;
  logic [IDX_W-1:0] ev_slot_q, ev_slot_d;
  logic [6:0] ev_note_q, ev_note_d;
  logic ev_on_q, ev_on_d;
  logic ev_oor_q, ev_oor_d;
  logic busy_q, busy_d;
  logic scan_done_q, scan_done_d;
  logic overrun_q, overrun_d;

  logic [9:0] cur_slot;

  // Next-state, shadow updates and registered-output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    force_d     = force_q;
    ev_valid_d  = ev_valid_q;
    ev_slot_d   = ev_slot_q;
    ev_note_d   = ev_note_q;
    ev_on_d     = ev_on_q;
    ev_oor_d    = ev_oor_q;
    cur_slot    = snap_q[idx_q];
    // A strobe anywhere but IDLE is dropped and flagged on the next cycle.
    overrun_d   = frame_stb && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (frame_stb) begin
          for (int k = 0; k < SLOTS; k++) begin
            snap_d[k] = pd_in[k*SLOT_W +: 10];
          end
          force_d = force_all;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if ((cur_slot != prev_q[idx_q]) || force_q) begin
          ev_slot_d  = idx_q;
          ev_note_d  = cur_slot[6:0] + NOTE_OFS7;
          ev_on_d    = cur_slot[9];
          ev_oor_d   = |cur_slot[8:7];
          ev_valid_d = 1'b1;
          state_d    = S_EMIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_EMIT: begin
        // prev only follows delivered values, so an undelivered change is
        // found again on the next frame.
        if (ev_valid_q && ev_ready) begin
          prev_d[idx_q] = cur_slot;
          ev_valid_d    = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    scan_done_d = (state_d == S_DONE);
  end

  // State, shadows and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      prev_q      <= '0;
      force_q     <= 1'b0;
      ev_valid_q  <= 1'b0;
      ev_slot_q   <= '0;
      ev_note_q   <= '0;
      ev_on_q     <= 1'b0;
      ev_oor_q    <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      force_q     <= force_d;
      ev_valid_q  <= ev_valid_d;
      ev_slot_q   <= ev_slot_d;
      ev_note_q   <= ev_note_d;
      ev_on_q     <= ev_on_d;
      ev_oor_q    <= ev_oor_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_slot   = ev_slot_q;
  assign ev_note   = ev_note_q;
  assign ev_on     = ev_on_q;
  assign ev_oor    = ev_oor_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_poly_disp_scan.sv
// Directed bench for poly_disp_scan: expected events are pushed into a queue
// as each frame is issued; a negedge monitor pops and compares on every
// ev_valid && ev_ready transfer and checks that stalled events stay stable.
module tb_poly_disp_scan;

  logic         clk;
  logic         reset_n;
  logic         frame_stb;
  logic         force_all;
  logic [255:0] pd_in;
  logic         ev_valid;
  logic         ev_ready;
  logic [3:0]   ev_slot;
  logic [6:0]   ev_note;
  logic         ev_on;
  logic         ev_oor;
  logic         busy;
  logic         scan_done;
  logic         overrun;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] exp_q[$];

  poly_disp_scan dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_stb (frame_stb),
    .force_all (force_all),
    .pd_in     (pd_in),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_slot   (ev_slot),
    .ev_note   (ev_note),
    .ev_on     (ev_on),
    .ev_oor    (ev_oor),
    .busy      (busy),
    .scan_done (scan_done),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, need completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [12:0] ev_pack(int s, int n, bit on, bit oor);
    logic [3:0] s4;
    logic [6:0] n7;
    s4 = 4'(s);
    n7 = 7'(n);
    return {s4, n7, on, oor};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(int k, logic [15:0] v);
    pd_in[k*16 +: 16] = v;
  endtask

  // ---------------- driver tasks ----------------
  // Returns #1 after the sampling edge (edge 0); the next negedge is cycle 1.
  task automatic issue_frame(bit f);
    @(posedge clk);
    #1;
    frame_stb = 1'b1;
    force_all = f;
    @(posedge clk);
    #1;
    frame_stb = 1'b0;
    force_all = 1'b0;
  endtask

  task automatic wait_valid(string name);
    int cnt;
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (ev_valid) break;
      cnt++;
    end
    check({name, "_valid_seen"}, 32'(ev_valid), 32'd1);
  endtask

  task automatic wait_done(string name);
    int cnt;
    cnt = 0;
    while (cnt < 500) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check({name, "_scan_finished"}, 32'(busy), 32'd0);
    check({name, "_events_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        held;
  logic [12:0] held_val;
  initial held = 1'b0;

  always @(negedge clk) begin
    logic [12:0] got;
    got = {ev_slot, ev_note, ev_on, ev_oor};
    if (!reset_n) begin
      held = 1'b0;
    end else if (ev_valid && ev_ready) begin
      if (held) check("stall_stable", 32'(got), 32'(held_val));
      held = 1'b0;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got 0x%0h, need no event at %0t", got, $time);
      end else begin
        check("event", 32'(got), 32'(exp_q.pop_front()));
      end
    end else if (ev_valid) begin
      if (held) check("stall_stable", 32'(got), 32'(held_val));
      held     = 1'b1;
      held_val = got;
    end else begin
      held = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    frame_stb = 1'b0;
    force_all = 1'b0;
    pd_in     = '0;
    ev_ready  = 1'b0;

    // Reset state: every output low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({ev_valid, ev_slot, ev_note, ev_on, ev_oor, busy, scan_done, overrun}),
          32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;

    // T1: empty bus, no events; busy cycles 1-17, scan_done only in cycle 17.
    issue_frame(1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 17));
      check($sformatf("t1_done_c%0d", c), 32'(scan_done), 32'(c == 17));
      check($sformatf("t1_valid_c%0d", c), 32'(ev_valid), 32'd0);
    end
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // T2: slot0 = 0x0218 -> note 24+36=60, on. Same frame again -> nothing.
    set_slot(0, 16'h0218);
    ev_ready = 1'b1;
    exp_q.push_back(ev_pack(0, 60, 1'b1, 1'b0));
    issue_frame(1'b0);
    wait_done("t2a");
    issue_frame(1'b0);
    wait_done("t2b");

    // T3: slots 3 and 15 change; first event stalled 5 cycles.
    set_slot(3, 16'h0200);
    set_slot(15, 16'h0018);
    ev_ready = 1'b0;
    exp_q.push_back(ev_pack(3, 36, 1'b1, 1'b0));
    exp_q.push_back(ev_pack(15, 60, 1'b0, 1'b0));
    issue_frame(1'b0);
    wait_valid("t3");
    check("t3_stall_slot", 32'(ev_slot), 32'd3);
    repeat (5) @(posedge clk);
    #1;
    ev_ready = 1'b1;
    wait_done("t3");

    // T4a: force_all on an unchanged bus -> all 16 slots in order.
    for (int s = 0; s < 16; s++) begin
      case (s)
        0:       exp_q.push_back(ev_pack(0, 60, 1'b1, 1'b0));
        3:       exp_q.push_back(ev_pack(3, 36, 1'b1, 1'b0));
        15:      exp_q.push_back(ev_pack(15, 60, 1'b0, 1'b0));
        default: exp_q.push_back(ev_pack(s, 36, 1'b0, 1'b0));
      endcase
    end
    issue_frame(1'b1);
    wait_done("t4a");

    // T4b: slot7 field 9'h180 -> oor, note 36. Slot5 only reserved bits -> no event.
    set_slot(5, 16'hFC00);
    set_slot(7, 16'h0180);
    exp_q.push_back(ev_pack(7, 36, 1'b0, 1'b1));
    issue_frame(1'b0);
    wait_done("t4b");

    // T5: second strobe in cycle 5, plus bus change mid-scan; neither matters.
    issue_frame(1'b0);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check($sformatf("t5_overrun_c%0d", c), 32'(overrun), 32'(c == 6));
      check($sformatf("t5_done_c%0d", c), 32'(scan_done), 32'(c == 17));
      check($sformatf("t5_busy_c%0d", c), 32'(busy), 32'(c <= 17));
      if (c == 5) begin
        frame_stb = 1'b1;
        set_slot(1, 16'h0255);
      end
      if (c == 6) frame_stb = 1'b0;
    end
    check("t5_queue", 32'(exp_q.size()), 32'd0);
    set_slot(1, 16'h0000);

    // T6: reset while an event is pending; afterwards every nonzero slot re-emits.
    ev_ready = 1'b0;
    issue_frame(1'b1);
    wait_valid("t6");
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_valid_dropped", 32'(ev_valid), 32'd0);
    check("t6_outputs_cleared",
          32'({ev_valid, ev_slot, ev_note, ev_on, ev_oor, busy, scan_done, overrun}),
          32'd0);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    ev_ready = 1'b1;
    exp_q.push_back(ev_pack(0, 60, 1'b1, 1'b0));
    exp_q.push_back(ev_pack(3, 36, 1'b1, 1'b0));
    exp_q.push_back(ev_pack(7, 36, 1'b0, 1'b1));
    exp_q.push_back(ev_pack(15, 60, 1'b0, 1'b0));
    issue_frame(1'b0);
    wait_done("t6");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
